// File: rtl/csr_reg_file_pkg.sv
// csr_reg_file_pkg
// Shared definitions for the machine-mode CSR block: data width, CSR
// addresses, mstatus bit positions, writable-field masks and the fixed misa
// value. Imported by csr_reg_file and csr_counter64.
package csr_reg_file_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned IRQ_SW_BIT    = 3;
  localparam int unsigned IRQ_TIMER_BIT = 7;
  localparam int unsigned IRQ_EXT_BIT   = 11;

  localparam logic [DATA_WIDTH-1:0] MIE_WMASK   = 32'h0000_0888;
  localparam logic [DATA_WIDTH-1:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [DATA_WIDTH-1:0] MEPC_WMASK  = 32'hFFFF_FFFC;
  localparam logic [DATA_WIDTH-1:0] MISA_VALUE  = 32'h4000_0100;

  // mstatus as seen by software: MPP is hardwired to machine mode.
  function automatic logic [DATA_WIDTH-1:0] mstatus_view(input logic mie,
                                                          input logic mpie);
    logic [DATA_WIDTH-1:0] v;
    v = ZERO;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_reg_file_counter64.sv
// csr_counter64
// 64-bit free-running counter with an increment enable and independent
// low/high half write strobes. A write to either half takes priority over the
// increment for the whole counter; the other half simply holds.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   inc_en_i         increment by one this cycle
//   we_lo_i, we_hi_i write bits 31:0 / 63:32 with wdata_i
//   wdata_i          write data
//   count_o          current count
module csr_counter64
  import csr_reg_file_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  inc_en_i,
  input  logic                  we_lo_i,
  input  logic                  we_hi_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [63:0]           count_o
);

  logic [63:0] count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (we_lo_i) begin
      count_q <= {count_q[63:32], wdata_i};
    end else if (we_hi_i) begin
      count_q <= {wdata_i, count_q[31:0]};
    end else if (inc_en_i) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_reg_file.sv
// csr_reg_file
// Machine-mode CSR storage. Returns the addressed CSR combinationally and
// commits software writes, trap entry and mret updates at the next rising
// edge. Also captures raw interrupt lines into mip and (optionally) keeps
// the 64-bit mcycle/minstret counters.
// Build option: define CSR_COUNTERS_EN to implement mcycle/minstret; without
// it those addresses stay mapped, read 0 and ignore writes.
// Ports:
//   clk_i, rst_n_i                      clock, async active-low reset
//   csr_raddr_i / csr_rdata_o           read address / combinational data
//   illegal_csr_o                       read address is unmapped
//   csr_we_i, csr_waddr_i, csr_wdata_i  software write
//   inst_retire_i                       instruction retired this cycle
//   trap_we_i, trap_mepc_i, trap_mcause_i  trap entry
//   mret_i                              mret this cycle
//   ext_irq_i, timer_irq_i, sw_irq_i    raw interrupt lines
//   mtvec_o, mepc_o                     current trap vector / return PC
//   global_int_en_o                     mstatus.MIE
//   irq_pending_o                       any enabled interrupt pending
module csr_reg_file
  import csr_reg_file_pkg::*;
#(
  parameter int unsigned           HART_ID     = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [11:0]           csr_raddr_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  illegal_csr_o,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_waddr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  input  logic                  inst_retire_i,
  input  logic                  trap_we_i,
  input  logic [DATA_WIDTH-1:0] trap_mepc_i,
  input  logic [DATA_WIDTH-1:0] trap_mcause_i,
  input  logic                  mret_i,
  input  logic                  ext_irq_i,
  input  logic                  timer_irq_i,
  input  logic                  sw_irq_i,
  output logic [DATA_WIDTH-1:0] mtvec_o,
  output logic [DATA_WIDTH-1:0] mepc_o,
  output logic                  global_int_en_o,
  output logic                  irq_pending_o
);

  logic                  mstatus_mie_q;
  logic                  mstatus_mpie_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
  logic [DATA_WIDTH-1:0] mscratch_q;
  logic [DATA_WIDTH-1:0] mie_q;
  logic [DATA_WIDTH-1:0] mip_q;
  logic [DATA_WIDTH-1:0] irq_vec;
  logic                  sw_we;

  // Trap entry and mret own the cycle; any software write alongside them is lost.
  assign sw_we = csr_we_i & ~trap_we_i & ~mret_i;

  always_comb begin
    irq_vec                = ZERO;
    irq_vec[IRQ_SW_BIT]    = sw_irq_i;
    irq_vec[IRQ_TIMER_BIT] = timer_irq_i;
    irq_vec[IRQ_EXT_BIT]   = ext_irq_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= ZERO;
      mcause_q       <= ZERO;
      mscratch_q     <= ZERO;
      mie_q          <= ZERO;
      mip_q          <= ZERO;
    end else begin
      mip_q <= irq_vec;
      if (trap_we_i) begin
        mepc_q         <= trap_mepc_i & MEPC_WMASK;
        mcause_q       <= trap_mcause_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (sw_we) begin
        case (csr_waddr_i)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
            mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= csr_wdata_i & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= csr_wdata_i & MTVEC_WMASK;
          CSR_MEPC:     mepc_q     <= csr_wdata_i & MEPC_WMASK;
          CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
          CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_counter64 u_mcycle (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .inc_en_i (1'b1),
    .we_lo_i  (sw_we && (csr_waddr_i == CSR_MCYCLE)),
    .we_hi_i  (sw_we && (csr_waddr_i == CSR_MCYCLEH)),
    .wdata_i  (csr_wdata_i),
    .count_o  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .inc_en_i (inst_retire_i),
    .we_lo_i  (sw_we && (csr_waddr_i == CSR_MINSTRET)),
    .we_hi_i  (sw_we && (csr_waddr_i == CSR_MINSTRETH)),
    .wdata_i  (csr_wdata_i),
    .count_o  (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = inst_retire_i;
`endif

  // No bypass from the write port: execute computes wdata from this value.
  always_comb begin
    csr_rdata_o   = ZERO;
    illegal_csr_o = 1'b0;
    case (csr_raddr_i)
      CSR_MSTATUS:   csr_rdata_o = mstatus_view(mstatus_mie_q, mstatus_mpie_q);
      CSR_MISA:      csr_rdata_o = MISA_VALUE;
      CSR_MIE:       csr_rdata_o = mie_q;
      CSR_MTVEC:     csr_rdata_o = mtvec_q;
      CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
      CSR_MEPC:      csr_rdata_o = mepc_q;
      CSR_MCAUSE:    csr_rdata_o = mcause_q;
      CSR_MIP:       csr_rdata_o = mip_q;
      CSR_MVENDORID: csr_rdata_o = ZERO;
      CSR_MARCHID:   csr_rdata_o = ZERO;
      CSR_MIMPID:    csr_rdata_o = ZERO;
      CSR_MHARTID:   csr_rdata_o = DATA_WIDTH'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
      CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
`else
      CSR_MCYCLE:    csr_rdata_o = ZERO;
      CSR_MCYCLEH:   csr_rdata_o = ZERO;
      CSR_MINSTRET:  csr_rdata_o = ZERO;
      CSR_MINSTRETH: csr_rdata_o = ZERO;
`endif
      default:       illegal_csr_o = 1'b1;
    endcase
  end

  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign global_int_en_o = mstatus_mie_q;
  assign irq_pending_o   = |(mie_q & mip_q);

endmodule
